rx_iq_byte_packer: RTL and testbench
====================================

# rx_iq_byte_packer

Buffers decimated I/Q sample pairs from the receiver's 24-bit output (`out_strobe`, `out_data_I`, `out_data_Q`) in a small FIFO. Serializes each pair into six bytes on a valid/ready byte stream for the openHPSDR protocol-1 frame assembler. Sits directly downstream of the receiver in the 122.88 MHz domain. Tolerates back-pressure from the packet builder and counts samples dropped on overflow.

## Interface
- `DEPTH_LOG2`, 4: FIFO depth is 2^DEPTH_LOG2 I/Q pairs.
- `OVF_WIDTH`, 16: width of the overflow counter.

Ports:
- `clock`  in  1  122.88 MHz system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_strobe`  in  1  one-cycle pulse; the I/Q pair on `in_data_*` is valid.
- `in_data_I`  in  24  signed I sample.
- `in_data_Q`  in  24  signed Q sample.
- `out_data`  out  8  current byte.
- `out_valid`  out  1  `out_data` is valid.
- `out_ready`  in  1  consumer accepts the byte when `out_valid` and `out_ready` are both high.
- `out_first`  out  1  current byte is byte 0 of a pair (I[23:16]).
- `out_last`  out  1  current byte is byte 5 of a pair (Q[7:0]).
- `level`  out  DEPTH_LOG2+1  pairs stored in the FIFO, excluding the pair being serialized.
- `overflow`  out  1  sticky flag: at least one pair was dropped.
- `overflow_count`  out  OVF_WIDTH  dropped pairs; saturates at all-ones.
- `clear_overflow`  in  1  clears `overflow` and `overflow_count`.

## Operation
- Byte order per pair, big-endian: I[23:16], I[15:8], I[7:0], Q[23:16], Q[15:8], Q[7:0].
- Write: on `in_strobe`, the pair is written if `level < 2^DEPTH_LOG2`, or if a pop happens in the same cycle. Otherwise the new pair is dropped and the FIFO contents are untouched.
- A drop sets `overflow` and increments `overflow_count`, saturating.
- `clear_overflow` in the same cycle as a drop: result is `overflow`=1, `overflow_count`=1.
- Serializer FSM:
  - IDLE: `out_valid`=0. If `level`≠0, issue FIFO read and pop, then go to LOAD.
  - LOAD: the FIFO's registered read data is loaded into the 48-bit shift register. Byte index is set to 0. Go to SEND.
  - SEND: `out_valid`=1. Each handshake advances the byte index.
    - On handshake at index 5 with `level`≠0: read and pop, go to LOAD.
    - On handshake at index 5 with `level`=0: go to IDLE.
- While `out_valid`=1 and `out_ready`=0, `out_data`, `out_first` and `out_last` hold stable. `out_valid` never drops before the handshake.
- `out_ready` is ignored while `out_valid`=0.
- `level` counts +1 on write and −1 on pop. A simultaneous write and pop leaves it unchanged.

## Timing
- Reset values:
  - `out_valid`=0, `out_first`=0, `out_last`=0, `out_data`=0.
  - `level`=0, `overflow`=0, `overflow_count`=0.
  - FSM in IDLE.
- Reset mid-pair discards the partial pair and all FIFO contents. `out_valid` is 0 in the cycle after reset is sampled.
- Latency with FIFO empty, FSM in IDLE and `out_ready`=1:
  - `in_strobe` in cycle c.
  - `level`=1 in cycle c+1; the read is issued in c+1.
  - `level`=0 again in cycle c+2.
  - First byte valid in cycle c+3.
  - Last byte accepted in cycle c+8.
- Back-to-back: if byte 5 is accepted in cycle k and `level`≠0, the next pair's byte 0 is valid in cycle k+2 (one bubble cycle). Sustained rate is 7 cycles per pair with `out_ready` held high.
- Maximum occupancy is 2^DEPTH_LOG2 stored pairs plus one pair in the shift register.

## Structure
- Shared package `rx_iq_pkg` holds:
  - `BYTES_PER_PAIR` = 6.
  - The FSM state enum (IDLE, LOAD, SEND).
  - The pair width constant, 48.
- Sub-module `rx_iq_fifo`: synchronous FIFO, 48-bit wide.
  - One-cycle registered read.
  - Write and read in the same cycle are allowed, including when full.
  - Outputs `level`.
- The top level holds:
  - The serializer FSM.
  - The overflow logic.

## Test plan
- Single pair: I=0x123456, Q=0xABCDEF, `out_ready`=1 → bytes 12 34 56 AB CD EF in cycles c+3..c+8. `out_first` is high on 0x12 only; `out_last` is high on 0xEF only.
- Back-pressure: toggle `out_ready` pseudo-randomly across 10 pairs → byte stream identical to the inputs, and `out_data` stable while stalled.
- Overflow: `out_ready`=0, 20 strobes with DEPTH_LOG2=4 → `level`=16 and `overflow_count`=3. The one pair in the shift register plus 16 stored are kept. Releasing `out_ready` yields pairs 1..17 in order.
- Full with a same-cycle pop: strobe in the cycle byte 5 is accepted while `level`=16 → the write is accepted, `overflow_count` is unchanged, `level` stays 16.
- `clear_overflow` coincident with a drop → `overflow`=1, `overflow_count`=1. Saturation: force 2^16+5 drops → `overflow_count`=0xFFFF.
- Reset asserted after byte 2 of a pair → `out_valid`=0 next cycle and `level`=0. The next strobe produces a full 6-byte pair starting at byte 0.

Source files
------------

// File: rtl/rx_iq_pkg.sv
// Shared constants for the receiver I/Q byte packer.
// Pair geometry and serializer state encoding.
package rx_iq_pkg;

  localparam int BYTES_PER_PAIR = 6;
  localparam int PAIR_W = 48;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_LOAD = 2'd1;
  localparam state_t S_SEND = 2'd2;

endpackage

// File: rtl/rx_iq_fifo.sv
// Synchronous pair FIFO with one-cycle registered read.
// Caller only writes when space exists or a read happens in the same cycle.
module rx_iq_fifo
  import rx_iq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en_i,
  input  logic [PAIR_W-1:0]     wr_data_i,
  input  logic                  rd_en_i,
  output logic [PAIR_W-1:0]     rd_data_o,
  output logic [DEPTH_LOG2:0]   level_o
);

  logic [PAIR_W-1:0]     mem_q [2**DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] wptr_q;
  logic [DEPTH_LOG2-1:0] rptr_q;
  logic [DEPTH_LOG2:0]   level_q;
  logic [DEPTH_LOG2:0]   level_d;
  logic [PAIR_W-1:0]     rdata_q;

  always_comb begin
    level_d = level_q;
    unique case ({wr_en_i, rd_en_i})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_en_i) wptr_q <= wptr_q + 1'b1;
      if (rd_en_i) begin
        rptr_q  <= rptr_q + 1'b1;
        rdata_q <= mem_q[rptr_q];
      end
      level_q <= level_d;
    end
  end

  // A write while full lands in the slot being read; the read sees old data.
  always_ff @(posedge clock) begin
    if (wr_en_i) mem_q[wptr_q] <= wr_data_i;
  end

  assign rd_data_o = rdata_q;
  assign level_o   = level_q;

endmodule

// File: rtl/rx_iq_byte_packer.sv
// Buffers 24-bit I/Q pairs and serializes each into six big-endian bytes.
// Counts pairs dropped when the FIFO is full and nothing is leaving.
module rx_iq_byte_packer
  import rx_iq_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4,
  parameter int OVF_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_strobe,
  input  logic [23:0]           in_data_I,
  input  logic [23:0]           in_data_Q,
  output logic [7:0]            out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_first,
  output logic                  out_last,
  output logic [DEPTH_LOG2:0]   level,
  output logic                  overflow,
  output logic [OVF_WIDTH-1:0]  overflow_count,
  input  logic                  clear_overflow
);

  localparam logic [DEPTH_LOG2:0] FULL =
    (DEPTH_LOG2+1)'(2**DEPTH_LOG2);
  localparam logic [2:0] LAST_IDX = 3'(BYTES_PER_PAIR - 1);

  state_t                state_q, state_d;
  logic [2:0]            idx_q, idx_d;
  logic [PAIR_W-1:0]     sh_q, sh_d;
  logic                  ovf_q, ovf_d;
  logic [OVF_WIDTH-1:0]  cnt_q, cnt_d;
  logic [PAIR_W-1:0]     rd_data;
  logic                  send, hs, has_data;
  logic                  pop, wr, drop;

  assign send     = (state_q == S_SEND);
  assign hs       = send && out_ready;
  assign has_data = (level != '0);
  assign pop      = has_data &&
                    ((state_q == S_IDLE) ||
                     (hs && idx_q == LAST_IDX));
  assign wr       = in_strobe && ((level < FULL) || pop);
  assign drop     = in_strobe && !wr;

  rx_iq_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .wr_en_i   (wr),
    .wr_data_i ({in_data_I, in_data_Q}),
    .rd_en_i   (pop),
    .rd_data_o (rd_data),
    .level_o   (level)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    unique case (state_q)
      S_IDLE: begin
        if (pop) state_d = S_LOAD;
      end
      S_LOAD: begin
        sh_d    = rd_data;
        idx_d   = '0;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          if (idx_q == LAST_IDX) begin
            state_d = has_data ? S_LOAD : S_IDLE;
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = sh_q << 8;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A drop coinciding with a clear counts as the first new drop.
  always_comb begin
    ovf_d = ovf_q;
    cnt_d = cnt_q;
    if (clear_overflow) begin
      ovf_d = drop;
      cnt_d = drop ? OVF_WIDTH'(1) : '0;
    end else if (drop) begin
      ovf_d = 1'b1;
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      sh_q    <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid      = send;
  assign out_data       = send ? sh_q[PAIR_W-1 -: 8] : '0;
  assign out_first      = send && (idx_q == '0);
  assign out_last       = send && (idx_q == LAST_IDX);
  assign overflow       = ovf_q;
  assign overflow_count = cnt_q;

endmodule

// File: tb/tb_rx_iq_byte_packer.sv
// Scoreboard bench for rx_iq_byte_packer.
// Stimulus pushes expected bytes; a negedge monitor pops and compares.
module tb_rx_iq_byte_packer;

  localparam int DL = 4;
  localparam int OW = 16;

  logic          clock;
  logic          reset;
  logic          in_strobe;
  logic [23:0]   in_data_I;
  logic [23:0]   in_data_Q;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_first;
  logic          out_last;
  logic [DL:0]   level;
  logic          overflow;
  logic [OW-1:0] overflow_count;
  logic          clear_overflow;

  rx_iq_byte_packer #(
    .DEPTH_LOG2 (DL),
    .OVF_WIDTH  (OW)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .in_strobe      (in_strobe),
    .in_data_I      (in_data_I),
    .in_data_Q      (in_data_Q),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_first      (out_first),
    .out_last       (out_last),
    .level          (level),
    .overflow       (overflow),
    .overflow_count (overflow_count),
    .clear_overflow (clear_overflow)
  );

  typedef struct {
    logic [7:0] d;
    logic       f;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   pairs_done = 0;
  bit   rnd_ready = 0;
  logic ready_ctl = 0;

  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Reference: a pair is 48 bits, bytes taken most significant first.
  function automatic void push_pair(input logic [23:0] i,
                                    input logic [23:0] q);
    longint p;
    exp_t   e;
    p = (longint'(i) << 24) + longint'(q);
    for (int k = 0; k < 6; k++) begin
      e.d = 8'((p >> (8 * (5 - k))) & 255);
      e.f = (k == 0);
      e.l = (k == 5);
      exp_q.push_back(e);
    end
  endfunction

  task automatic send(input logic [23:0] i,
                      input logic [23:0] q,
                      input bit keep);
    in_data_I = i;
    in_data_Q = q;
    in_strobe = 1'b1;
    if (keep) push_pair(i, q);
    @(posedge clock);
    #1;
    in_strobe = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge clock);
      n++;
    end
    #1;
    chk("drain_left", 64'(exp_q.size()), 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    exp_q.delete();
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : ready_ctl;
    end
  end

  initial begin
    bit         prev_stall = 0;
    logic [9:0] prev_v = '0;
    exp_t       e;
    forever begin
      @(negedge clock);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", 64'(out_valid), 1);
          chk("hold_byte", 64'({out_data, out_first, out_last}),
              64'(prev_v));
        end
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_byte: got %0h expected none",
                     out_data);
          end else begin
            e = exp_q.pop_front();
            chk("byte", 64'(out_data), 64'(e.d));
            chk("first", 64'(out_first), 64'(e.f));
            chk("last", 64'(out_last), 64'(e.l));
            if (e.l) pairs_done++;
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_v     = {out_data, out_first, out_last};
      end
    end
  end

  initial begin
    logic [7:0]  lat_b [6];
    logic [23:0] ri, rq;
    int          n, hsn;

    lat_b = '{8'h12, 8'h34, 8'h56, 8'hAB, 8'hCD, 8'hEF};
    reset = 1'b1;
    in_strobe = 1'b0;
    in_data_I = '0;
    in_data_Q = '0;
    clear_overflow = 1'b0;

    @(posedge clock);
    #1;
    @(negedge clock);
    chk("rst_valid", 64'(out_valid), 0);
    chk("rst_first", 64'(out_first), 0);
    chk("rst_last", 64'(out_last), 0);
    chk("rst_data", 64'(out_data), 0);
    chk("rst_level", 64'(level), 0);
    chk("rst_ovf", 64'(overflow), 0);
    chk("rst_cnt", 64'(overflow_count), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;

    // single pair latency
    ready_ctl = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    send(24'h123456, 24'hABCDEF, 1);
    @(negedge clock);
    chk("lat_level1", 64'(level), 1);
    @(negedge clock);
    chk("lat_level0", 64'(level), 0);
    chk("lat_nvalid", 64'(out_valid), 0);
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("lat_valid", 64'(out_valid), 1);
      chk("lat_byte", 64'(out_data), 64'(lat_b[k]));
    end
    @(negedge clock);
    chk("lat_end", 64'(out_valid), 0);
    wait_drain();

    // random back-pressure and gaps
    rnd_ready = 1;
    for (int p = 0; p < 12; p++) begin
      repeat ($urandom_range(0, 8)) @(posedge clock);
      #1;
      ri = 24'($urandom);
      rq = 24'($urandom);
      send(ri, rq, 1);
    end
    rnd_ready = 0;
    ready_ctl = 1'b1;
    wait_drain();

    // overflow with stalled consumer
    ready_ctl = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int p = 1; p <= 20; p++) begin
      ri = 24'($urandom);
      rq = 24'($urandom);
      send(ri, rq, p <= 17);
    end
    @(negedge clock);
    chk("ovf_level", 64'(level), 16);
    chk("ovf_cnt", 64'(overflow_count), 3);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_holding", 64'(out_valid), 1);

    // write while full on the cycle byte 5 is accepted
    ready_ctl = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (!(out_valid && out_last && out_ready) && n < 100);
    chk("full_pop_timeout", 64'(n < 100), 1);
    send(24'h0F1E2D, 24'h3C4B5A, 1);
    @(negedge clock);
    chk("full_pop_level", 64'(level), 16);
    chk("full_pop_cnt", 64'(overflow_count), 3);
    wait_drain();

    // clear coinciding with a drop, then saturation
    pulse_reset();
    ready_ctl = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    for (int p = 0; p < 17; p++) begin
      send(24'($urandom), 24'($urandom), 1);
    end
    clear_overflow = 1'b1;
    send(24'hFFFFFF, 24'h000000, 0);
    clear_overflow = 1'b0;
    @(negedge clock);
    chk("clr_drop_flag", 64'(overflow), 1);
    chk("clr_drop_cnt", 64'(overflow_count), 1);
    @(posedge clock);
    #1;
    in_strobe = 1'b1;
    repeat ((1 << 16) + 4) @(posedge clock);
    #1;
    in_strobe = 1'b0;
    @(negedge clock);
    chk("sat_cnt", 64'(overflow_count), 64'hFFFF);
    chk("sat_level", 64'(level), 16);
    @(posedge clock);
    #1;
    clear_overflow = 1'b1;
    @(posedge clock);
    #1;
    clear_overflow = 1'b0;
    @(negedge clock);
    chk("clr_cnt", 64'(overflow_count), 0);
    chk("clr_flag", 64'(overflow), 0);
    ready_ctl = 1'b1;
    wait_drain();

    // reset after byte 2 of a pair
    send(24'hA1B2C3, 24'hD4E5F6, 1);
    send(24'h111111, 24'h222222, 1);
    n = 0;
    hsn = 0;
    while (hsn < 3 && n < 50) begin
      @(negedge clock);
      n++;
      if (out_valid && out_ready) hsn++;
    end
    chk("rst_mid_timeout", 64'(hsn), 3);
    @(posedge clock);
    #1;
    pulse_reset();
    @(negedge clock);
    chk("rst_mid_valid", 64'(out_valid), 0);
    chk("rst_mid_level", 64'(level), 0);
    @(posedge clock);
    #1;
    send(24'h5A5A5A, 24'hC3C3C3, 1);
    wait_drain();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
